// File: rtl/pr_bridge_timer_if.sv
// rtl/pr_bridge_timer_if.sv - CPU processor-bus signals between the CPU and the bridge
interface pr_bridge_timer_if;
    logic [29:0] pr_addr;
    logic [31:0] pr_wd;
    logic [3:0]  pr_be;
    logic [31:0] pr_rd;

    modport master (output pr_addr, output pr_wd, output pr_be, input pr_rd);
    modport slave  (input pr_addr, input pr_wd, input pr_be, output pr_rd);
endinterface

// File: rtl/pr_bridge_timer.sv
// rtl/pr_bridge_timer.sv - CPU bus responder with a down-counter timer and a device window
module pr_bridge_timer #(
    parameter logic [31:0] TIMER_BASE = 32'h0000_7F00,
    parameter logic [31:0] DEV_BASE   = 32'h0000_7F10
) (
    input  logic                    clk,
    input  logic                    rst,
    pr_bridge_timer_if.slave        bus,
    output logic [5:0]              hw_int,
    output logic [1:0]              dev_addr,
    output logic [31:0]             dev_wd,
    output logic                    dev_we,
    input  logic [31:0]             dev_rd,
    input  logic [4:0]              ext_irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_pend_q, irq_pend_d;

    logic        timer_hit, dev_hit, wr;
    logic [1:0]  offset;
    logic        ctrl_we, preset_we;
    logic        unused_be;

    // pr_addr is a word address, so bits [29:2] line up with byte-address bits [31:4]
    assign timer_hit = (bus.pr_addr[29:2] == TIMER_BASE[31:4]);
    assign dev_hit   = (bus.pr_addr[29:2] == DEV_BASE[31:4]);
    assign wr        = bus.pr_be[1];
    assign offset    = bus.pr_addr[1:0];
    assign unused_be = ^{bus.pr_be[3:2], bus.pr_be[0]};

    assign ctrl_we   = timer_hit & wr & (offset == 2'd0);
    assign preset_we = timer_hit & wr & (offset == 2'd1);

    assign dev_addr  = offset;
    assign dev_wd    = bus.pr_wd;
    assign dev_we    = dev_hit & wr;

    assign hw_int    = {ext_irq, irq_pend_q & ctrl_q[3]};

    always_comb begin
        bus.pr_rd = 32'd0;
        if (timer_hit) begin
            case (offset)
                2'd0:    bus.pr_rd = {28'd0, ctrl_q};
                2'd1:    bus.pr_rd = preset_q;
                2'd2:    bus.pr_rd = count_q;
                default: bus.pr_rd = 32'd0;
            endcase
        end else if (dev_hit) begin
            bus.pr_rd = dev_rd;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_pend_d = irq_pend_q;

        case (state_q)
            S_IDLE: begin
                if (ctrl_q[0]) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = S_IDLE;
                end else if (count_q <= 32'd1) begin
                    count_d = 32'd0;
                    state_d = S_INT;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            S_INT: begin
                irq_pend_d = 1'b1;
                if (ctrl_q[2:1] == 2'b01) begin
                    state_d = S_LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A bus CTRL write overrides the FSM's own EN clear, but never hides a fresh terminal event
        if (ctrl_we) begin
            ctrl_d = bus.pr_wd[3:0];
            if (state_q != S_INT) irq_pend_d = 1'b0;
            if (!bus.pr_wd[0]) state_d = S_IDLE;
        end
        if (preset_we) preset_d = bus.pr_wd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_pend_q <= irq_pend_d;
        end
    end

endmodule

// File: tb/tb_pr_bridge_timer.sv
// tb/tb_pr_bridge_timer.sv - self-checking bench for pr_bridge_timer
module tb_pr_bridge_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hw_int;
    logic [1:0]  dev_addr;
    logic [31:0] dev_wd;
    logic        dev_we;
    logic [31:0] dev_rd;
    logic [4:0]  ext_irq;

    pr_bridge_timer_if bus();

    pr_bridge_timer dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .hw_int   (hw_int),
        .dev_addr (dev_addr),
        .dev_wd   (dev_wd),
        .dev_we   (dev_we),
        .dev_rd   (dev_rd),
        .ext_irq  (ext_irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: timer run described by the cycle of its LOAD and the latched preset
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset, m_count;
    logic        m_pend;
    longint      m_load;
    longint      m_p;
    longint      k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint int_cycle();
        return m_load + ((m_p == 0) ? 1 : m_p) + 1;
    endfunction

    function automatic logic int_now();
        return (m_load >= 0) && (k > m_load) && (k == int_cycle());
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (a[31:4] == 28'h00007F0) begin
            case (a[3:2])
                2'd0:    return {28'd0, m_ctrl};
                2'd1:    return m_preset;
                2'd2:    return m_count;
                default: return 32'd0;
            endcase
        end
        if (a[31:4] == 28'h00007F1) return dev_rd;
        return 32'd0;
    endfunction

    task automatic model_edge();
        logic [31:0] a;
        logic        thit, ev;
        longint      nload, r;
        logic [31:0] ncnt;
        logic        npend;
        logic [3:0]  nctrl;
        if (rst) begin
            m_ctrl = 0; m_preset = 0; m_count = 0; m_pend = 0; m_load = -1; m_p = 0;
            return;
        end
        a = {bus.pr_addr, 2'b00};
        thit = (a[31:4] == 28'h00007F0) && bus.pr_be[1];
        nload = m_load; ncnt = m_count; npend = m_pend; nctrl = m_ctrl; ev = 1'b0;
        if (m_load >= 0 && k == m_load) begin
            m_p = longint'(m_preset);
            ncnt = m_preset;
        end else if (m_load >= 0 && k > m_load) begin
            if (k < int_cycle()) begin
                r = m_p - (k - m_load);
                ncnt = (r > 0) ? r[31:0] : 32'd0;
            end else begin
                ev = 1'b1;
                npend = 1'b1;
                if (m_ctrl[2:1] == 2'b01) nload = k + 1;
                else begin nctrl[0] = 1'b0; nload = -1; end
            end
        end
        if (thit && a[3:2] == 2'd0) begin
            nctrl = bus.pr_wd[3:0];
            if (!ev) npend = 1'b0;
            if (!bus.pr_wd[0]) nload = -1;
            else if (nload < 0) nload = k + 2;
        end
        if (thit && a[3:2] == 2'd1) m_preset = bus.pr_wd;
        m_ctrl = nctrl; m_count = ncnt; m_pend = npend; m_load = nload;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #2;
        k++;
    endtask

    task automatic set_bus(input logic [31:0] a, input logic [31:0] d, input logic w);
        bus.pr_addr = a[31:2];
        bus.pr_wd   = d;
        bus.pr_be   = {2'($urandom_range(0, 3)), w, 1'($urandom_range(0, 1))};
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        set_bus(a, d, 1'b1);
        tick();
        set_bus(32'h7F00, $urandom, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        set_bus(a, $urandom, 1'b0);
        #1;
        d = bus.pr_rd;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] d;
        for (int off = 0; off < 3; off++) begin
            rd(32'h7F00 + 32'(off * 4), d);
            chk($sformatf("%s_reg%0d", tag, off), d, exp_rd(32'h7F00 + 32'(off * 4)));
        end
        chk({tag, "_hwint"}, {26'd0, hw_int}, {26'd0, ext_irq, m_pend & m_ctrl[3]});
    endtask

    logic [31:0] d;
    int          found;
    int          t2_cnt [6] = '{5, 4, 3, 2, 1, 0};

    initial begin
        k = 0; m_load = -1; m_p = 0;
        m_ctrl = 0; m_preset = 0; m_count = 0; m_pend = 0;
        rst = 1'b1; ext_irq = 5'd0; dev_rd = $urandom;
        set_bus(32'h7F00, 32'd0, 1'b0);
        tick(); tick();
        rst = 1'b0;

        // 1: reset state
        rd(32'h7F00, d); chk("t1_ctrl", d, 32'd0);
        rd(32'h7F04, d); chk("t1_preset", d, 32'd0);
        rd(32'h7F08, d); chk("t1_count", d, 32'd0);
        chk("t1_hwint", {26'd0, hw_int}, 32'd0);

        // 2: one-shot with PRESET=5
        ext_irq = 5'($urandom);
        wr(32'h7F04, 32'd5);
        wr(32'h7F00, 32'h9);
        tick(); check_all("t2_load");
        for (int i = 0; i < 6; i++) begin
            tick();
            check_all("t2_run");
            rd(32'h7F08, d); chk("t2_count_seq", d, 32'(t2_cnt[i]));
            if (i == 5) chk("t2_irq_at_int", {31'd0, hw_int[0]}, 32'd0);
        end
        tick();
        chk("t2_irq_after_int", {31'd0, hw_int[0]}, 32'd1);
        rd(32'h7F00, d); chk("t2_en_cleared", d, 32'h8);
        wr(32'h7F00, 32'h8);
        chk("t2_irq_cleared", {31'd0, hw_int[0]}, 32'd0);
        check_all("t2_end");

        // 3: auto-reload, PRESET change mid-count
        wr(32'h7F04, 32'd3);
        wr(32'h7F00, 32'hB);
        for (int i = 0; i < 14; i++) begin tick(); check_all("t3_a"); end
        wr(32'h7F04, 32'd7);
        check_all("t3_pw");
        for (int i = 0; i < 30; i++) begin tick(); check_all("t3_b"); end
        wr(32'h7F00, 32'h0);

        // 4: PRESET=0 never wraps
        wr(32'h7F04, 32'd0);
        wr(32'h7F00, 32'h9);
        tick();
        tick(); rd(32'h7F08, d); chk("t4_cnt0", d, 32'd0);
        tick(); chk("t4_no_irq_yet", {31'd0, hw_int[0]}, 32'd0);
        tick(); chk("t4_irq", {31'd0, hw_int[0]}, 32'd1);
        rd(32'h7F08, d); chk("t4_no_wrap", d, 32'd0);
        check_all("t4_end");

        // 5: ignored writes, device window, unmapped reads, pr_be[1]=0
        wr(32'h7F08, $urandom); rd(32'h7F08, d); chk("t5_count_ro", d, 32'd0);
        wr(32'h7F0C, $urandom); rd(32'h7F0C, d); chk("t5_off_c", d, 32'd0);
        wr(32'h1000, $urandom); check_all("t5_unmapped_wr");
        set_bus(32'h7F14, 32'hA5A5_1234, 1'b1); #1;
        chk("t5_dev_we", {31'd0, dev_we}, 32'd1);
        chk("t5_dev_addr", {30'd0, dev_addr}, 32'd1);
        chk("t5_dev_wd", dev_wd, 32'hA5A5_1234);
        tick();
        dev_rd = $urandom;
        rd(32'h7F14, d); chk("t5_dev_rd", d, dev_rd);
        chk("t5_dev_we_rd", {31'd0, dev_we}, 32'd0);
        rd(32'h1000, d); chk("t5_rd_1000", d, 32'd0);
        set_bus(32'h7F00, 32'hFFFF_FFF7, 1'b0); tick(); check_all("t5_be_ctrl");
        set_bus(32'h7F04, $urandom, 1'b0); tick(); check_all("t5_be_preset");

        // 6a: CTRL write coincident with INT
        wr(32'h7F04, 32'd2);
        wr(32'h7F00, 32'h9);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (int_now()) found = 1; else tick();
        end
        chk("t6_reach_int", found, 1);
        wr(32'h7F00, 32'hB);
        chk("t6_pend_wins", {31'd0, hw_int[0]}, 32'd1);
        rd(32'h7F00, d); chk("t6_ctrl_written", d, 32'hB);
        for (int i = 0; i < 8; i++) begin tick(); check_all("t6_after"); end

        // 6b: reset mid-count at COUNT=3
        wr(32'h7F04, 32'd10);
        wr(32'h7F00, 32'h9);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (m_load >= 0 && k > m_load && m_count == 32'd3) found = 1; else tick();
        end
        chk("t6_reach_cnt3", found, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        rd(32'h7F00, d); chk("t6_rst_ctrl", d, 32'd0);
        rd(32'h7F04, d); chk("t6_rst_preset", d, 32'd0);
        rd(32'h7F08, d); chk("t6_rst_count", d, 32'd0);
        chk("t6_rst_irq", {31'd0, hw_int[0]}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 11);
            ext_irq = 5'($urandom);
            dev_rd = $urandom;
            rst = ($urandom_range(0, 60) == 0);
            case (op)
                0, 1, 2: set_bus(32'h7F00, {$urandom_range(0, 32'h0FFF_FFFF), 3'($urandom), 1'($urandom_range(0, 5) != 0)}, 1'b1);
                3, 4:    set_bus(32'h7F04, $urandom_range(0, 6), 1'b1);
                5:       set_bus(32'h7F08 + 32'($urandom_range(0, 1) * 4), $urandom, 1'b1);
                6:       set_bus(32'h7F00 + 32'($urandom_range(0, 1) * 4), $urandom, 1'b0);
                7:       set_bus(32'h7F10 + 32'($urandom_range(0, 3) * 4), $urandom, 1'b1);
                default: set_bus(32'h7F08, $urandom, 1'b0);
            endcase
            #1;
            chk("rnd_dev_we", {31'd0, dev_we}, {31'd0, (op == 7)});
            tick();
            rst = 1'b0;
            check_all("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
